// File: rtl/sudoku_input_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_input_ctrl
//   Push-button front end for the VGA Sudoku game. Synchronises and debounces
//   the five Basys3 buttons and turns accepted presses into registered,
//   single-cycle engine commands. It also runs the MOVE/NUMBER mode machine
//   and drives the cursor-flash and number-preview signals for sudoku_draw.
//
//   Optional feature: define SUDOKU_AUTOREPEAT_EN to build held-button
//   auto-repeat for U/D/L/R. Without it, a held button gives one pulse only.
//
// Ports
//   clk             : system clock (100 MHz)
//   reset_n         : asynchronous active-low reset
//   btn_raw[4:0]    : raw buttons {R,L,D,U,C}, bit0 = C
//   mode            : 0 = MOVE, 1 = NUMBER
//   selected_number : current number selection, 1..MAX_VALUE
//   preview_number  : selected_number while in NUMBER mode, else 0
//   flash_visible   : flash phase while in NUMBER mode, else 1
//   cmd_up/down/left/right : single-cycle cursor-move pulses
//   cmd_number      : committed value alongside cmd_valid; 0 for moves
//   cmd_valid       : single-cycle strobe for any engine command
//   cmd_enter       : single-cycle pulse on every accepted C press
// -----------------------------------------------------------------------------
module sudoku_input_ctrl #(
    parameter int  DEBOUNCE_CYCLES = 1_000_000,
    parameter int  REPEAT_DELAY    = 50_000_000,
    parameter int  REPEAT_RATE     = 15_000_000,
    parameter int  MAX_VALUE       = 9,
    parameter int  FLASH_BITS      = 27,
    localparam int VAL_W           = $clog2(MAX_VALUE + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       btn_raw,
    output logic             mode,
    output logic [VAL_W-1:0] selected_number,
    output logic [VAL_W-1:0] preview_number,
    output logic             flash_visible,
    output logic             cmd_up,
    output logic             cmd_down,
    output logic             cmd_left,
    output logic             cmd_right,
    output logic [VAL_W-1:0] cmd_number,
    output logic             cmd_valid,
    output logic             cmd_enter
);

    localparam int NUM_BTN = 5;
    localparam int B_C = 0, B_U = 1, B_D = 2, B_L = 3, B_R = 4;

    localparam int                    CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]      DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DB_ONE    = CNT_W'(1);
    localparam logic [VAL_W-1:0]      VAL_ONE   = VAL_W'(1);
    localparam logic [VAL_W-1:0]      VAL_MAX   = VAL_W'(MAX_VALUE);
    localparam logic [FLASH_BITS-1:0] FLASH_ONE = FLASH_BITS'(1);

    typedef enum logic {MODE_MOVE = 1'b0, MODE_NUMBER = 1'b1} mode_e;

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE ||
        MAX_VALUE < 2) begin : g_param_check
        $error("sudoku_input_ctrl: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BTN-1:0] clean_q, clean_d, clean_dly_q, clean_dly_d;
    logic [NUM_BTN-1:0] ev_q, ev_d;
    logic [CNT_W-1:0]   db_cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] rep;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        clean_d     = clean_q;
        clean_dly_d = clean_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = '0;
            // Count consecutive samples that disagree with the accepted level.
            if (sync2_q[i] != clean_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end
        end
        press = clean_q & ~clean_dly_q;
        ev_d  = press | rep;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            clean_q     <= '0;
            clean_dly_q <= '0;
            ev_q        <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it takes the async reset too.
            for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            clean_q     <= clean_d;
            clean_dly_q <= clean_dly_d;
            ev_q        <= ev_d;
            for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat for the direction buttons
    // ------------------------------------------------------------------
`ifdef SUDOKU_AUTOREPEAT_EN
    localparam int               HOLD_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q [B_U:B_R];
    logic [HOLD_W-1:0] hold_d [B_U:B_R];

    // hold counts cycles since the last pulse. After the first repeat it is
    // reloaded so the next one lands REPEAT_RATE cycles later.
    always_comb begin
        rep = '0;
        for (int i = B_U; i <= B_R; i++) begin
            hold_d[i] = hold_q[i] + HOLD_ONE;
            if (!clean_q[i] || press[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] == HOLD_LAST) begin
                rep[i]    = 1'b1;
                hold_d[i] = HOLD_RELOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = B_U; i <= B_R; i++) hold_q[i] <= '0;
        end else begin
            for (int i = B_U; i <= B_R; i++) hold_q[i] <= hold_d[i];
        end
    end
`else
    assign rep = '0;
`endif

    // ------------------------------------------------------------------
    // Mode FSM: state register / next-state / registered outputs
    // ------------------------------------------------------------------
    mode_e             mode_q, mode_d;
    logic [VAL_W-1:0]  sel_q, sel_d, preview_q, preview_d, cmd_number_q, cmd_number_d;
    logic [FLASH_BITS-1:0] flash_cnt_q, flash_cnt_d;
    logic flash_vis_q, flash_vis_d;
    logic cmd_up_q, cmd_up_d, cmd_down_q, cmd_down_d;
    logic cmd_left_q, cmd_left_d, cmd_right_q, cmd_right_d;
    logic cmd_valid_q, cmd_valid_d, cmd_enter_q, cmd_enter_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mode_q <= MODE_MOVE;
        else          mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_MOVE:   if (ev_q[B_C]) mode_d = MODE_NUMBER;
            MODE_NUMBER: if (ev_q[B_C]) mode_d = MODE_MOVE;
            default:     mode_d = MODE_MOVE;
        endcase
    end

    // Decisions use the mode registered before this cycle, so a C press
    // together with a direction pulse acts on the direction in the old mode.
    always_comb begin
        sel_d        = sel_q;
        cmd_up_d     = 1'b0;
        cmd_down_d   = 1'b0;
        cmd_left_d   = 1'b0;
        cmd_right_d  = 1'b0;
        cmd_valid_d  = 1'b0;
        cmd_number_d = '0;
        cmd_enter_d  = ev_q[B_C];
        case (mode_q)
            MODE_MOVE: begin
                cmd_up_d    = ev_q[B_U];
                cmd_down_d  = ev_q[B_D] & ~ev_q[B_U];
                cmd_left_d  = ev_q[B_L];
                cmd_right_d = ev_q[B_R];
                cmd_valid_d = |ev_q[B_R:B_U];
            end
            MODE_NUMBER: begin
                if (ev_q[B_U])      sel_d = (sel_q == VAL_MAX) ? VAL_ONE : sel_q + VAL_ONE;
                else if (ev_q[B_D]) sel_d = (sel_q == VAL_ONE) ? VAL_MAX : sel_q - VAL_ONE;
                if (ev_q[B_C]) begin
                    cmd_valid_d  = 1'b1;
                    cmd_number_d = sel_q;
                end
            end
            default: ;
        endcase
        flash_cnt_d = flash_cnt_q + FLASH_ONE;
        // Built from next-state values so the registered outputs match mode and counter.
        preview_d   = (mode_d == MODE_NUMBER) ? sel_d : '0;
        flash_vis_d = (mode_d == MODE_NUMBER) ? flash_cnt_d[FLASH_BITS-1] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q        <= VAL_ONE;
            preview_q    <= '0;
            flash_cnt_q  <= '0;
            flash_vis_q  <= 1'b1;
            cmd_up_q     <= 1'b0;
            cmd_down_q   <= 1'b0;
            cmd_left_q   <= 1'b0;
            cmd_right_q  <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_number_q <= '0;
            cmd_enter_q  <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            preview_q    <= preview_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_vis_q  <= flash_vis_d;
            cmd_up_q     <= cmd_up_d;
            cmd_down_q   <= cmd_down_d;
            cmd_left_q   <= cmd_left_d;
            cmd_right_q  <= cmd_right_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_number_q <= cmd_number_d;
            cmd_enter_q  <= cmd_enter_d;
        end
    end

    assign mode            = (mode_q == MODE_NUMBER);
    assign selected_number = sel_q;
    assign preview_number  = preview_q;
    assign flash_visible   = flash_vis_q;
    assign cmd_up          = cmd_up_q;
    assign cmd_down        = cmd_down_q;
    assign cmd_left        = cmd_left_q;
    assign cmd_right       = cmd_right_q;
    assign cmd_number      = cmd_number_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_enter       = cmd_enter_q;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sudoku_input_ctrl
//   Directed bench for sudoku_input_ctrl with a behavioural reference model.
//   The model works from button-level rules: a level is accepted after a
//   window of agreeing samples, and repeats are timed from the press. All
//   outputs are compared every cycle, and hand-computed literals pin down
//   latency, counts and values.
// -----------------------------------------------------------------------------
module tb_sudoku_input_ctrl;

    localparam int DEB = 4, RDLY = 20, RRATE = 5, MAXV = 9, FBITS = 4;
    localparam int VW  = 4;
    localparam int BC = 0, BU = 1, BD = 2, BL = 3, BR = 4;
`ifdef SUDOKU_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [4:0]    btn_raw;
    logic          mode, flash_visible;
    logic [VW-1:0] selected_number, preview_number, cmd_number;
    logic          cmd_up, cmd_down, cmd_left, cmd_right, cmd_valid, cmd_enter;

    sudoku_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_RATE     (RRATE),
        .MAX_VALUE       (MAXV),
        .FLASH_BITS      (FBITS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .btn_raw         (btn_raw),
        .mode            (mode),
        .selected_number (selected_number),
        .preview_number  (preview_number),
        .flash_visible   (flash_visible),
        .cmd_up          (cmd_up),
        .cmd_down        (cmd_down),
        .cmd_left        (cmd_left),
        .cmd_right       (cmd_right),
        .cmd_number      (cmd_number),
        .cmd_valid       (cmd_valid),
        .cmd_enter       (cmd_enter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Clock edges since reset release.
    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit [4:0] m_hist [0:7];     // m_hist[k] = raw buttons sampled k edges ago
    bit [4:0] m_clean, m_clean_prev, m_ev, m_ev_next;
    int       m_press_t [5];
    int       m_n;
    bit       m_all;
    bit       m_mode, m_up, m_down, m_left, m_right, m_valid, m_enter, m_flash;
    int       m_sel, m_num, m_prev;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) m_hist[k] = '0;
            for (int i = 0; i < 5; i++) m_press_t[i] = 0;
            m_clean = '0; m_clean_prev = '0; m_ev = '0; m_n = 0;
            m_mode = 1'b0; m_sel = 1; m_prev = 0; m_num = 0; m_flash = 1'b1;
            {m_up, m_down, m_left, m_right, m_valid, m_enter} = '0;
        end else begin
            m_n++;
            for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = btn_raw;

            // Commands from the events accepted on the previous cycle.
            {m_up, m_down, m_left, m_right, m_valid} = '0;
            m_num   = 0;
            m_enter = m_ev[BC];
            if (!m_mode) begin
                m_up    = m_ev[BU];
                m_down  = m_ev[BD] && !m_ev[BU];
                m_left  = m_ev[BL];
                m_right = m_ev[BR];
                m_valid = m_ev[BU] || m_ev[BD] || m_ev[BL] || m_ev[BR];
                if (m_ev[BC]) m_mode = 1'b1;
            end else begin
                if (m_ev[BC]) begin
                    m_valid = 1'b1;
                    m_num   = m_sel;
                end
                if (m_ev[BU])      m_sel = (m_sel == MAXV) ? 1 : m_sel + 1;
                else if (m_ev[BD]) m_sel = (m_sel == 1) ? MAXV : m_sel - 1;
                if (m_ev[BC]) m_mode = 1'b0;
            end
            m_flash = m_mode ? bit'((m_n / 8) % 2) : 1'b1;
            m_prev  = m_mode ? m_sel : 0;

            // Events: a rising accepted level, or a repeat timed from that press.
            for (int i = 0; i < 5; i++) begin
                m_ev_next[i] = 1'b0;
                if (m_clean[i] && !m_clean_prev[i]) begin
                    m_ev_next[i] = 1'b1;
                    m_press_t[i] = m_n;
                end else if (AUTOREP && i != BC && m_clean[i] &&
                             (m_n - m_press_t[i] >= RDLY) &&
                             ((m_n - m_press_t[i] - RDLY) % RRATE == 0)) begin
                    m_ev_next[i] = 1'b1;
                end
            end
            m_ev = m_ev_next;

            // Accepted level flips once DEB synchronised samples all disagree with it.
            m_clean_prev = m_clean;
            for (int i = 0; i < 5; i++) begin
                m_all = 1'b1;
                for (int k = 2; k <= DEB + 1; k++)
                    if (m_hist[k][i] == m_clean_prev[i]) m_all = 1'b0;
                if (m_all) m_clean[i] = ~m_clean_prev[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare and pulse logging
    // ------------------------------------------------------------------
    int up_times[$], right_times[$], valid_times[$], valid_nums[$], enter_times[$];

    always @(negedge clk) begin
        if (reset_n) begin
            check("mode",            mode,            m_mode);
            check("selected_number", selected_number, m_sel);
            check("preview_number",  preview_number,  m_prev);
            check("flash_visible",   flash_visible,   m_flash);
            check("cmd_up",          cmd_up,          m_up);
            check("cmd_down",        cmd_down,        m_down);
            check("cmd_left",        cmd_left,        m_left);
            check("cmd_right",       cmd_right,       m_right);
            check("cmd_valid",       cmd_valid,       m_valid);
            check("cmd_number",      cmd_number,      m_num);
            check("cmd_enter",       cmd_enter,       m_enter);
            if (cmd_up)    up_times.push_back(cyc);
            if (cmd_right) right_times.push_back(cyc);
            if (cmd_valid) begin
                valid_times.push_back(cyc);
                valid_nums.push_back(int'(cmd_number));
            end
            if (cmd_enter) enter_times.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic clear_logs();
        up_times.delete(); right_times.delete(); valid_times.delete();
        valid_nums.delete(); enter_times.delete();
    endtask

    // Called just after a falling edge; holds the mask, then idles.
    task automatic hold_btn(input logic [4:0] mask, input int n_hold, input int n_idle);
        btn_raw = mask;
        repeat (n_hold) @(negedge clk);
        btn_raw = '0;
        repeat (n_idle) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " mode"},       mode,            0);
        check({tag, " selected"},   selected_number, 1);
        check({tag, " preview"},    preview_number,  0);
        check({tag, " flash"},      flash_visible,   1);
        check({tag, " cmd_dirs"},   {cmd_up, cmd_down, cmd_left, cmd_right}, 0);
        check({tag, " cmd_valid"},  cmd_valid,       0);
        check({tag, " cmd_number"}, cmd_number,      0);
        check({tag, " cmd_enter"},  cmd_enter,       0);
    endtask

`ifdef SUDOKU_AUTOREPEAT_EN
    int exp_up_off[$] = {0, 20, 25, 30, 35};
`else
    int exp_up_off[$] = {0};
`endif

    initial begin
        int start;
        int tog[$];
        logic prev_flash;

        reset_n = 1'b0;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Debounce latency: R held 12 cycles -> one move pulse after edge 7.
        clear_logs();
        start = cyc;
        hold_btn(5'b1_0000, 12, 12);
        check("right count", right_times.size(), 1);
        check("right latency", (right_times.size() > 0) ? right_times[0] - (start + 1) : -1, 7);
        check("right valid count", valid_times.size(), 1);
        check("right cmd_number", (valid_nums.size() > 0) ? valid_nums[0] : -1, 0);

        // A 3-cycle glitch must not get through.
        clear_logs();
        hold_btn(5'b1_0000, 3, 12);
        check("glitch right count", right_times.size(), 0);
        check("glitch valid count", valid_times.size(), 0);

        // Enter NUMBER mode.
        clear_logs();
        hold_btn(5'b0_0001, 6, 8);
        check("number mode", mode, 1);
        check("number preview", preview_number, 1);
        check("enter on C in MOVE", enter_times.size(), 1);
        check("no valid on C in MOVE", valid_times.size(), 0);

        // Flash phase toggles every 8 cycles.
        prev_flash = flash_visible;
        repeat (34) begin
            @(negedge clk);
            if (flash_visible !== prev_flash) tog.push_back(cyc);
            prev_flash = flash_visible;
        end
        check("flash toggles", (tog.size() >= 3) ? 1 : 0, 1);
        check("flash period a", (tog.size() >= 2) ? tog[1] - tog[0] : -1, 8);
        check("flash period b", (tog.size() >= 3) ? tog[2] - tog[1] : -1, 8);

        // U x8 reaches 9, two more wrap to 1 then 2.
        repeat (8) hold_btn(5'b0_0010, 6, 8);
        check("sel after U x8", selected_number, 9);
        repeat (2) hold_btn(5'b0_0010, 6, 8);
        check("sel after U x10", selected_number, 2);
        check("preview tracks sel", preview_number, 2);
        hold_btn(5'b0_0100, 6, 8);
        check("sel after D x1", selected_number, 1);
        hold_btn(5'b0_0100, 6, 8);
        check("sel after D x2", selected_number, 9);
        hold_btn(5'b0_0100, 6, 8);
        check("sel after D x3", selected_number, 8);

        // Commit 8.
        clear_logs();
        hold_btn(5'b0_0001, 6, 8);
        check("commit valid count", valid_times.size(), 1);
        check("commit number", (valid_nums.size() > 0) ? valid_nums[0] : -1, 8);
        check("commit enter count", enter_times.size(), 1);
        check("commit enter with valid",
              (valid_times.size() > 0 && enter_times.size() > 0) ? enter_times[0] - valid_times[0] : -1, 0);
        check("commit mode", mode, 0);
        check("commit preview", preview_number, 0);
        check("commit flash", flash_visible, 1);

        // Auto-repeat: hold U for 40 cycles in MOVE.
        clear_logs();
        hold_btn(5'b0_0010, 40, 12);
        check("repeat up count", up_times.size(), exp_up_off.size());
        foreach (exp_up_off[i])
            check("repeat up offset",
                  (i < up_times.size()) ? up_times[i] - up_times[0] : -1, exp_up_off[i]);
        check("repeat mode stays", mode, 0);

        // C and U accepted together in MOVE.
        clear_logs();
        hold_btn(5'b0_0011, 6, 10);
        check("simul up count", up_times.size(), 1);
        check("simul valid count", valid_times.size(), 1);
        check("simul enter count", enter_times.size(), 1);
        check("simul mode", mode, 1);
        check("simul sel unchanged", selected_number, 8);

        // Async reset mid-hold in NUMBER mode.
        btn_raw = 5'b0_0010;
        repeat (12) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async");
        repeat (3) @(negedge clk);
        clear_logs();
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        btn_raw = '0;
        repeat (10) @(negedge clk);
        check("post-reset up count", up_times.size(), 1);
        check("post-reset up latency", (up_times.size() > 0) ? up_times[0] : -1, 8);
        check("post-reset mode", mode, 0);
        check("post-reset sel", selected_number, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sudoku_input_ctrl.md
# sudoku_input_ctrl

Parametrised button front end for the VGA Sudoku game. It sits between the raw Basys3 push-buttons and `sudoku_engine`, and replaces the separate debounce, one-pulse and mode logic. It debounces N buttons and manages the MOVE/NUMBER mode state machine with a configurable value range (9×9 or 16×16 boards). It also adds held-button auto-repeat, and emits registered single-cycle engine commands plus the cursor-flash and preview signals for `sudoku_draw`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (≥2).
- `REPEAT_DELAY`, default 50_000_000: cycles a direction button must be held before the first auto-repeat.
- `REPEAT_RATE`, default 15_000_000: cycles between subsequent auto-repeats (≥1).
- `MAX_VALUE`, default 9: highest selectable number (9 or 16). `VAL_W = $clog2(MAX_VALUE+1)`.
- `FLASH_BITS`, default 27: width of the free-running flash counter; its MSB is the flash phase.
- `clk  in  1`: 100 MHz system clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `btn_raw  in  5`: raw buttons, bit order {R,L,D,U,C} (bit0 = C).
- `mode  out  1`: 0 = MOVE, 1 = NUMBER.
- `selected_number  out  VAL_W`: current number selection, range 1..MAX_VALUE.
- `preview_number  out  VAL_W`: `selected_number` in NUMBER mode, else 0.
- `flash_visible  out  1`: flash counter MSB in NUMBER mode, else 1.
- `cmd_up`, `cmd_down`, `cmd_left`, `cmd_right`  out  1 each: single-cycle cursor-move pulses.
- `cmd_number  out  VAL_W`: value qualified by `cmd_valid`; 0 when the command is a move.
- `cmd_valid  out  1`: single-cycle strobe for any engine command.
- `cmd_enter  out  1`: single-cycle pulse on every accepted C press.

## Operation
- **Synchroniser, per button:** 2-FF synchroniser producing `s`.
- **Debounce, per button:**
  - Counter clears whenever `s == clean`.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES-1` with `s != clean`: `clean <= s` and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` never reach `clean`.
- **Press pulse:** registered `clean & ~clean_q`.
- **Auto-repeat (U/D/L/R only, never C):**
  - A per-button hold counter starts at the press.
  - First repeat pulse fires at `REPEAT_DELAY` cycles after the press pulse, then one every `REPEAT_RATE` cycles while `clean` stays 1.
  - Release clears the counter immediately.
  - A repeat pulse behaves identically to a press pulse.
- **Mode FSM:**
  - MOVE: C press → NUMBER. U/D/L/R pulses → the matching `cmd_*` with `cmd_valid=1` and `cmd_number=0`.
  - NUMBER: U pulse increments `selected_number` (MAX_VALUE wraps to 1). D pulse decrements it (1 wraps to MAX_VALUE). L/R are ignored. C press → `cmd_valid=1`, `cmd_number=selected_number`, mode → MOVE.
  - `cmd_enter` = every C press, in either mode.
- **Simultaneous events:** decisions use the mode registered before the cycle. Example: C and U pulses in the same MOVE cycle give `cmd_up`+`cmd_valid` and mode→NUMBER, with the selection unchanged. At most one of U/D acts per cycle; U has priority.
- `selected_number` persists across mode changes.
- **Reset values:**
  - mode = MOVE, selected_number = 1, preview_number = 0.
  - All `cmd_*` = 0, `cmd_valid` = 0, `cmd_enter` = 0.
  - flash counter = 0, so `flash_visible` = 1.
  - All clean levels = 0; debounce and hold counters = 0.
- Reset asserted mid-press: everything returns to the reset values. A button still held after reset release produces a fresh press after the full debounce time.

## Timing
- A raw edge sampled at clock edge 0 produces a `cmd_*`/`cmd_valid` pulse visible for exactly one cycle, after edge `DEBOUNCE_CYCLES+3`.
- `mode` and `selected_number` update on the same edge the command pulse rises.
- All outputs are registered. There are no combinational paths from `btn_raw`.
- A held button yields exactly one press pulse. Without repeat, no further pulses until it has been released and re-debounced.

## Configuration
- `SUDOKU_AUTOREPEAT_EN` defined: auto-repeat hardware is present, as described above.
- Not defined: hold counters are removed. A held direction button produces only its initial pulse. `REPEAT_DELAY` and `REPEAT_RATE` are ignored.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, MAX_VALUE=9, FLASH_BITS=4.

- **Debounce latency:** press R for 12 cycles → single `cmd_right`+`cmd_valid` pulse after edge 7 with `cmd_number=0`. A 3-cycle R glitch → no pulse.
- **Number entry:** C press → mode=1, `preview_number=1`, `flash_visible` toggles every 8 cycles. U ×10 → `selected_number` 1→…→9→1→2. D ×3 → 2→1→9→8.
- **Commit:** in NUMBER with selection 8, C press → one cycle with `cmd_valid=1`, `cmd_number=8`, `cmd_enter=1`; mode=0; `preview_number=0`.
- **Auto-repeat:** hold U for 40 cycles in MOVE → `cmd_up` pulses at press, press+20, +25, +30, +35. With the macro undefined → the initial pulse only.
- **Simultaneous:** C and U released by the debouncers on the same cycle in MOVE → `cmd_up=1`, mode→1, `selected_number` unchanged.
- **Async reset:** drop `reset_n` mid-hold while in NUMBER → all outputs return to the reset values immediately, before the next clock edge.
